// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding word memory responder. A request is accepted in IDLE,
//   waits LATENCY clock edges, then the access is performed and the response
//   is held until the initiator takes it.
//
//   Handshake semantics: a transfer happens on a rising clk edge where both
//   valid and ready are 1. req_ready is 1 only in IDLE. resp_valid, resp_rdata
//   and resp_err stay stable until the edge where resp_ready=1. req_valid
//   outside IDLE and resp_ready while resp_valid=0 have no effect.
//
//   Optional feature: define DMEM_ERR_CHECK_EN to flag misaligned or
//   out-of-range addresses with resp_err=1 (no store, rdata=0). When it is
//   undefined, addr[1:0] is ignored and the word index wraps modulo DEPTH.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   LATENCY    edges from acceptance to resp_valid (1..15)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_*      request channel (valid/ready, write, byte addr, store data)
//   resp_*     response channel (valid/ready, load data, error flag)
//   dbg_state  current FSM state (IDLE=0, WAIT=1, RESP=2)

module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam int         AW  = $clog2(DEPTH);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            accept;
   logic            finish;

   // Request fields captured at acceptance so later input changes are inert.
   logic            wr_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            err_q;
   logic            req_err;

   logic [31:0]     mem [DEPTH];

`ifdef DMEM_ERR_CHECK_EN
   assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
`else
   assign req_err = 1'b0;
`endif

   // Address bits outside the word index only matter with error checking.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

   assign req_ready = (state_q == IDLE);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               cnt_d   = LAT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // The edge on which the counter would reach zero is the access edge.
            if (cnt_q == 4'd1) begin
               finish  = 1'b1;
               cnt_d   = 4'd0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            wr_q    <= req_write;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
         end
         if (finish) begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (wr_q || err_q) ? 32'd0 : mem[idx_q];
         end else if ((state_q == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

   // Storage has no reset. finish is only ever 1 outside reset because the
   // asynchronous reset holds the FSM in IDLE, so an aborted store is dropped.
   always_ff @(posedge clk) begin
      if (finish && wr_q && !err_q) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int LAT_MAIN = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  dbg_state;

   logic        r1_req_valid, r1_req_ready, r1_req_write;
   logic [31:0] r1_req_addr, r1_req_wdata;
   logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
   logic [31:0] r1_resp_rdata;
   logic [1:0]  r1_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   logic [32:0] exp_q[$];
   int          lat_q[$];
   logic [32:0] r1_exp_q[$];
   int          r1_lat_q[$];
   int          r1_last_acc = -1;

   data_mem_responder #(.DEPTH(1024), .LATENCY(LAT_MAIN)) u_dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
   );

   data_mem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst_n),
      .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_write(r1_req_write),
      .req_addr(r1_req_addr), .req_wdata(r1_req_wdata),
      .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
      .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err), .dbg_state(r1_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge; returns at the negedge after acceptance.
   task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [32:0] e);
      int n;
      n = 0;
      req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (!req_ready) begin
         check("req_accept_timeout", {63'd0, req_ready}, 64'd1);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      lat_q.push_back(cycle + 1 + LAT_MAIN);
      @(posedge clk); #1;
      // Scramble the request inputs: the transaction in flight must not care.
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 300) begin @(negedge clk); n++; end
      check("drain_done", {63'd0, (exp_q.size() == 0 && req_ready)}, 64'd1);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
      check("resp_valid_timeout", {63'd0, resp_valid}, 64'd1);
   endtask

   task automatic reset_pulse_checked(input string tag);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_valid"}, {63'd0, resp_valid}, 64'd0);
      check({tag, "_rst_rdata"}, {32'd0, resp_rdata}, 64'd0);
      check({tag, "_rst_err"},   {63'd0, resp_err},   64'd0);
      check({tag, "_rst_ready"}, {63'd0, req_ready},  64'd1);
      check({tag, "_rst_state"}, {62'd0, dbg_state},  64'd0);
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic r1_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
      int n;
      int acc;
      n = 0;
      r1_req_write = wr; r1_req_addr = a; r1_req_wdata = d; r1_req_valid = 1'b1;
      while (!r1_req_ready && n < 20) begin @(negedge clk); n++; end
      if (!r1_req_ready) begin
         check("r1_accept_timeout", {63'd0, r1_req_ready}, 64'd1);
         return;
      end
      acc = cycle + 1;
      if (r1_last_acc >= 0) check("r1_b2b_spacing", 64'(acc - r1_last_acc), 64'd3);
      r1_last_acc = acc;
      r1_exp_q.push_back({1'b0, exp_rd});
      r1_lat_q.push_back(acc + 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- monitors / scoreboard ----------------
   logic        prev_v = 1'b0;
   logic [32:0] held;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (resp_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 64'd1, 64'd0);
            end else begin
               check("resp_data_err", {31'd0, resp_err, resp_rdata}, {31'd0, exp_q.pop_front()});
               check("resp_latency", 64'(cycle), 64'(lat_q.pop_front()));
            end
            held = {resp_err, resp_rdata};
         end else if (resp_valid && prev_v) begin
            check("resp_stable", {31'd0, resp_err, resp_rdata}, {31'd0, held});
            check("ready_low_in_resp", {63'd0, req_ready}, 64'd0);
         end
         prev_v = resp_valid;
      end
   end

   logic r1_prev_v = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         r1_prev_v = 1'b0;
      end else begin
         if (r1_resp_valid && !r1_prev_v) begin
            if (r1_exp_q.size() == 0) begin
               check("r1_unexpected_resp", 64'd1, 64'd0);
            end else begin
               check("r1_resp_data_err", {31'd0, r1_resp_err, r1_resp_rdata},
                     {31'd0, r1_exp_q.pop_front()});
               check("r1_resp_latency", 64'(cycle), 64'(r1_lat_q.pop_front()));
            end
         end
         r1_prev_v = r1_resp_valid;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      resp_ready = 1'b1;
      r1_req_valid = 1'b0; r1_req_write = 1'b0; r1_req_addr = 32'd0; r1_req_wdata = 32'd0;
      r1_resp_ready = 1'b1;
      #1;
      check("init_ready", {63'd0, req_ready},  64'd1);
      check("init_valid", {63'd0, resp_valid}, 64'd0);
      check("init_rdata", {32'd0, resp_rdata}, 64'd0);
      check("init_err",   {63'd0, resp_err},   64'd0);
      check("init_state", {62'd0, dbg_state},  64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Store then load
      do_req(1'b1, 32'h10, 32'hDEADBEEF, {1'b0, 32'h0});
      drain();
      do_req(1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF});
      drain();

      // More patterns, including the last word
      do_req(1'b1, 32'h0,   32'h00000001, {1'b0, 32'h0});
      do_req(1'b1, 32'hFFC, 32'hFFFFFFFF, {1'b0, 32'h0});
      do_req(1'b0, 32'hFFC, 32'h0,        {1'b0, 32'hFFFFFFFF});
      do_req(1'b0, 32'h0,   32'h0,        {1'b0, 32'h00000001});
      drain();

      // Backpressure for 10 cycles
      resp_ready = 1'b0;
      do_req(1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF});
      wait_valid();
      repeat (10) @(negedge clk);
      check("bp_ready_low", {63'd0, req_ready}, 64'd0);
      check("bp_valid_high", {63'd0, resp_valid}, 64'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_cleared", {63'd0, resp_valid}, 64'd0);
      check("bp_ready_back", {63'd0, req_ready}, 64'd1);
      drain();

      // Reset aborts an uncommitted store
      do_req(1'b1, 32'h20, 32'h0BADF00D, {1'b0, 32'h0});
      drain();
      do_req(1'b1, 32'h20, 32'h12345678, {1'b0, 32'h0});
      @(negedge clk);
      reset_pulse_checked("abort");
      @(negedge clk);
      do_req(1'b0, 32'h20, 32'h0, {1'b0, 32'h0BADF00D});
      drain();

      // Reset while holding a response; storage survives reset
      resp_ready = 1'b0;
      do_req(1'b0, 32'hFFC, 32'h0, {1'b0, 32'hFFFFFFFF});
      wait_valid();
      reset_pulse_checked("resp");
      resp_ready = 1'b1;
      @(negedge clk);
      do_req(1'b0, 32'hFFC, 32'h0, {1'b0, 32'hFFFFFFFF});
      do_req(1'b0, 32'h10,  32'h0, {1'b0, 32'hDEADBEEF});
      drain();

`ifdef DMEM_ERR_CHECK_EN
      do_req(1'b1, 32'h22,   32'h55555555, {1'b1, 32'h0});
      do_req(1'b0, 32'h20,   32'h0,        {1'b0, 32'h0BADF00D});
      do_req(1'b0, 32'h1000, 32'h0,        {1'b1, 32'h0});
      drain();
`else
      do_req(1'b1, 32'h1004, 32'hA5A5A5A5, {1'b0, 32'h0});
      do_req(1'b0, 32'h4,    32'h0,        {1'b0, 32'hA5A5A5A5});
      do_req(1'b0, 32'h7,    32'h0,        {1'b0, 32'hA5A5A5A5});
      drain();
`endif

      // LATENCY=1 instance, req_valid held high across back-to-back requests
      r1_op(1'b1, 32'h0, 32'h11111111, 32'h0);
      r1_op(1'b1, 32'h4, 32'h22222222, 32'h0);
      r1_op(1'b1, 32'h8, 32'h33333333, 32'h0);
      r1_op(1'b0, 32'h8, 32'h0, 32'h33333333);
      r1_op(1'b0, 32'h0, 32'h0, 32'h11111111);
      r1_op(1'b0, 32'h4, 32'h0, 32'h22222222);
      r1_req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("r1_queue_empty", 64'(r1_exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_timeout: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the number of 32-bit storage words (power of two, >= 2).
REQ-002 Parameter LATENCY, default 4, SHALL set the number of clock edges from request acceptance to response (legal range 1..15).
REQ-003 Clocking and reset SHALL be one clock, with an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store word, 0 = load word.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  access error flag, qualified by resp_valid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; one outstanding request at most; no pipelining.
REQ-017 In IDLE with req_valid=1 at a rising edge, the block SHALL accept the request at that edge: latch req_write/req_addr/req_wdata, load the counter with LATENCY, and enter WAIT.
REQ-018 In WAIT the counter SHALL decrement each edge; the edge on which it would reach 0 SHALL perform the access, load resp_rdata/resp_err, set resp_valid=1 and enter RESP.
REQ-019 resp_valid SHALL first be 1 exactly LATENCY edges after the acceptance edge (LATENCY=1: the next edge).
REQ-020 Store commit SHALL occur on the same edge that raises resp_valid; the word index SHALL be addr[log2(DEPTH)+1:2].
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1 at an edge; on that edge the block SHALL clear resp_valid and return to IDLE.
REQ-022 A new request SHALL NOT be accepted on the resp handshake edge; it SHALL be accepted no earlier than the following edge (req_ready rises after return to IDLE).
REQ-023 resp_ready while resp_valid=0 SHALL be ignored; req_valid outside IDLE SHALL be ignored.
REQ-024 Changes to latched request inputs after acceptance SHALL NOT affect the transaction in flight.
REQ-025 A load immediately following a store to the same address SHALL return the stored data.

Reset
REQ-026 Reset assertion SHALL immediately force IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready SHALL be 1 while reset=0.
REQ-027 Reset mid-transaction SHALL abort the transaction; a store not yet committed SHALL be discarded.
REQ-028 Storage contents SHALL NOT be altered by reset.

Configuration
REQ-029 Macro DMEM_ERR_CHECK_EN defined: a request with addr[1:0]!=0 or word index >= DEPTH (addr >= 4*DEPTH) SHALL produce resp_err=1 and resp_rdata=0, with no storage write, at the normal LATENCY.
REQ-030 Macro DMEM_ERR_CHECK_EN undefined: resp_err SHALL be tied to 0; addr[1:0] SHALL be ignored and the word index SHALL wrap modulo DEPTH.

Verification
REQ-031 Store then load (default parameters): store 0xDEADBEEF to addr 0x10; after the response handshake, load 0x10 -> resp_valid 4 edges after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-032 Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid/resp_rdata stable throughout and req_ready=0; raise resp_ready -> return to IDLE, req_ready=1 on the next cycle.
REQ-033 LATENCY=1 back-to-back: req_valid held high for 3 loads with resp_ready=1 -> each response 1 edge after its acceptance, one request accepted every 3 cycles.
REQ-034 Reset abort: store 0x12345678 to addr 0x20, assert reset 2 cycles after acceptance -> outputs cleared immediately; a later load of 0x20 returns the prior value, unchanged.
REQ-035 Errors with DMEM_ERR_CHECK_EN: store to 0x22 -> resp_err=1, and a later load of 0x20 returns the prior value unchanged; load from 0x1000 with DEPTH=1024 -> resp_err=1, resp_rdata=0.
REQ-036 Without DMEM_ERR_CHECK_EN: store 0xA5A5A5A5 to 0x1004 with DEPTH=1024, then load 0x4 -> 0xA5A5A5A5, resp_err=0.
